// File: rtl/svcs_sched_pkg.sv
// Shared header layout, link constants and FSM state encoding for the
// transaction scheduler.
package svcs_sched_pkg;

  localparam int HDR_WORDS     = 4;
  localparam int SVCS_MAX_SIZE = 4096;
  localparam int SVCS_WORD_W   = 32;

  localparam logic [31:0] ABORT_WORD = 32'hDEAD_DEAD;

  // Field order matches the wire order of the header words (first word in the MSBs)
  typedef struct packed {
    logic [SVCS_WORD_W-1:0] trnx_type;
    logic [SVCS_WORD_W-1:0] trnx_id;
    logic [SVCS_WORD_W-1:0] data_type;
    logic [SVCS_WORD_W-1:0] n_payloads;
  } cs_hdr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    PLD   = 2'd2,
    ABORT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/svcs_rr_arbiter.sv
// Round-robin arbiter: the registered pointer names the highest-priority
// index and moves to the slot after each accepted grant.
module svcs_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic [IDX_W-1:0] ptr_reg;

  // Scan from lowest to highest priority so the last hit is the winner
  always_comb begin
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_reg) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        any_req   = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
    grant[grant_idx] = any_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (advance) begin
      ptr_reg <= (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/svcs_trnx_sched.sv
// Multi-requester transaction scheduler: arbitrates, sends a 4-word header,
// then streams payload words. Optional stall abort: SVCS_TRNX_TIMEOUT_EN.
module svcs_trnx_sched
  import svcs_sched_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int DATA_W       = 32,
  parameter  int MAX_PAYLOADS = SVCS_MAX_SIZE,
  parameter  int TIMEOUT_CYC  = 256,
  localparam int IDX_W        = $clog2(N_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ*HDR_WORDS*DATA_W-1:0] req_hdr,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0]                pld_valid,
  input  logic [N_REQ*DATA_W-1:0]         pld_data,
  output logic [N_REQ-1:0]                pld_ready,
  output logic                            tx_valid,
  output logic [DATA_W-1:0]               tx_data,
  output logic                            tx_last,
  input  logic                            tx_ready,
  output logic [IDX_W-1:0]                grant_id,
  output logic                            busy,
  output logic                            err_len,
  output logic                            err_timeout
);

  localparam int CNT_W = $clog2(MAX_PAYLOADS + 1);

  logic [HDR_WORDS*DATA_W-1:0] hdr_arr [N_REQ];
  logic [DATA_W-1:0]           pld_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign hdr_arr[gi] = req_hdr[gi*HDR_WORDS*DATA_W +: HDR_WORDS*DATA_W];
      assign pld_arr[gi] = pld_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  sched_state_t                         state_reg;
  logic [IDX_W-1:0]                     grant_id_reg;
  logic [HDR_WORDS-1:0][DATA_W-1:0]     hdr_reg;
  logic [1:0]                           word_idx_reg;
  logic [CNT_W-1:0]                     cnt_reg;
  logic                                 busy_reg;
  logic                                 tx_valid_reg;
  logic [DATA_W-1:0]                    tx_data_reg;
  logic                                 tx_last_reg;

  logic [N_REQ-1:0]            arb_grant;
  logic [IDX_W-1:0]            arb_idx;
  logic                        arb_any;
  logic                        accept;
  logic [HDR_WORDS*DATA_W-1:0] sel_hdr;
  logic [DATA_W-1:0]           sel_n;
  logic                        oversize;
  logic                        in_pld;
  logic                        own_valid;
  logic [1:0]                  next_word;

  assign accept   = (state_reg == IDLE) && arb_any && !rst;
  assign sel_hdr  = hdr_arr[arb_idx];
  assign sel_n    = sel_hdr[DATA_W-1:0];
  assign oversize = sel_n > DATA_W'(MAX_PAYLOADS);

  svcs_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  assign req_ready = accept ? arb_grant : '0;
  assign err_len   = accept && oversize;

  // Payload words bypass the registers so the link sees the owner's stream directly
  assign in_pld    = (state_reg == PLD);
  assign own_valid = pld_valid[grant_id_reg];
  assign tx_valid  = in_pld ? own_valid : tx_valid_reg;
  assign tx_data   = in_pld ? pld_arr[grant_id_reg] : tx_data_reg;
  assign tx_last   = in_pld ? (own_valid && (cnt_reg == CNT_W'(1))) : tx_last_reg;
  assign grant_id  = grant_id_reg;
  assign busy      = busy_reg;
  assign next_word = word_idx_reg + 2'd1;

  always_comb begin
    pld_ready = '0;
    if (in_pld) pld_ready[grant_id_reg] = tx_ready;
  end

`ifdef SVCS_TRNX_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);
  logic [STALL_W-1:0] stall_reg;
  logic               err_timeout_reg;
  assign err_timeout = err_timeout_reg;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_id_reg <= '0;
      hdr_reg      <= '0;
      word_idx_reg <= '0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
      tx_last_reg  <= 1'b0;
`ifdef SVCS_TRNX_TIMEOUT_EN
      stall_reg       <= '0;
      err_timeout_reg <= 1'b0;
`endif
    end else begin
`ifdef SVCS_TRNX_TIMEOUT_EN
      err_timeout_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (accept && !oversize) begin
            state_reg    <= HDR;
            grant_id_reg <= arb_idx;
            hdr_reg      <= sel_hdr;
            word_idx_reg <= '0;
            cnt_reg      <= CNT_W'(sel_n);
            busy_reg     <= 1'b1;
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= sel_hdr[HDR_WORDS*DATA_W-1 -: DATA_W];
            tx_last_reg  <= 1'b0;
`ifdef SVCS_TRNX_TIMEOUT_EN
            stall_reg    <= '0;
`endif
          end
        end
        HDR: begin
          if (tx_ready) begin
            if (word_idx_reg == 2'd3) begin
              tx_valid_reg <= 1'b0;
              tx_last_reg  <= 1'b0;
              if (cnt_reg == '0) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end else begin
                state_reg <= PLD;
              end
            end else begin
              // hdr_reg[3] is the first word on the wire, so word k lives at index 3-k
              word_idx_reg <= next_word;
              tx_data_reg  <= hdr_reg[2'd3 - next_word];
              tx_last_reg  <= (next_word == 2'd3) && (cnt_reg == '0);
            end
          end
        end
        PLD: begin
          if (own_valid && tx_ready) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
`ifdef SVCS_TRNX_TIMEOUT_EN
          if (own_valid) begin
            stall_reg <= '0;
          end else if (stall_reg == STALL_W'(TIMEOUT_CYC - 1)) begin
            state_reg       <= ABORT;
            stall_reg       <= '0;
            tx_valid_reg    <= 1'b1;
            tx_data_reg     <= DATA_W'(ABORT_WORD);
            tx_last_reg     <= 1'b1;
            err_timeout_reg <= 1'b1;
          end else begin
            stall_reg <= stall_reg + STALL_W'(1);
          end
`endif
        end
        ABORT: begin
          if (tx_ready) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            tx_valid_reg <= 1'b0;
            tx_last_reg  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svcs_trnx_sched.sv
// Scoreboard bench for svcs_trnx_sched; the abort scenario runs only when
// SVCS_TRNX_TIMEOUT_EN is defined.
module tb_svcs_trnx_sched;
  import svcs_sched_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N*128-1:0] req_hdr = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     pld_valid = '0;
  logic [N*DW-1:0]  pld_data = '0;
  logic [N-1:0]     pld_ready;
  logic             tx_valid;
  logic [DW-1:0]    tx_data;
  logic             tx_last;
  logic             tx_ready = 1'b1;
  logic [1:0]       grant_id;
  logic             busy;
  logic             err_len;
  logic             err_timeout;

  svcs_trnx_sched #(.N_REQ(N), .DATA_W(DW), .MAX_PAYLOADS(4096), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_hdr(req_hdr), .req_ready(req_ready),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_ready(pld_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic last; } tx_exp_t;
  typedef struct { int req; logic err; } gnt_exp_t;

  tx_exp_t     exp_tx[$];
  gnt_exp_t    exp_grant[$];
  logic [31:0] pq[N][$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          grant_seen = 0;
  int          to_seen = 0;
  logic        rand_mode = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endfunction

  // Payload sources: each requester streams its queue, popping on a completed handshake
  always begin : feeder
    logic [N-1:0] fire;
    @(negedge clk);
    for (int r = 0; r < N; r++) begin
      fire[r] = !rst && pld_valid[r] && pld_ready[r];
      if (rst) pq[r].delete();
    end
    @(posedge clk); #1;
    for (int r = 0; r < N; r++) begin
      if (fire[r]) void'(pq[r].pop_front());
      pld_valid[r] = (pq[r].size() > 0);
      pld_data[r*DW +: DW] = (pq[r].size() > 0) ? pq[r][0] : '0;
    end
  end

  always begin : link_ready
    @(posedge clk); #1;
    tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compares every grant and link transfer against the scoreboard queues
  logic        prev_stall = 1'b0, prev_last = 1'b0, gid_pending = 1'b0, last_pending = 1'b0;
  logic [31:0] prev_data = '0;
  int          gid_exp = 0;
  always @(negedge clk) begin : monitor
    gnt_exp_t g;
    tx_exp_t  e;
    if (rst) begin
      prev_stall = 1'b0; gid_pending = 1'b0; last_pending = 1'b0;
    end else begin
      if (gid_pending) begin
        chk("grant_id", 64'(grant_id), 64'(gid_exp));
        chk("busy_rise", 64'(busy), 64'd1);
        gid_pending = 1'b0;
      end
      if (last_pending) begin
        chk("busy_fall", 64'(busy), 64'd0);
        last_pending = 1'b0;
      end
      if (prev_stall)
        chk("stall_hold", {31'd0, tx_valid, tx_last, tx_data}, {31'd0, 1'b1, prev_last, prev_data});
      if (req_ready != '0 || err_len) begin
        if (exp_grant.size() == 0) begin
          chk("unexpected_grant", {err_len, req_ready}, 64'd0);
        end else begin
          g = exp_grant.pop_front();
          chk("req_ready", 64'(req_ready), 64'd1 << g.req);
          chk("err_len", 64'(err_len), 64'(g.err));
          $display("t=%0t grant req=%0d err_len=%0b", $time, g.req, err_len);
          if (!g.err) begin gid_pending = 1'b1; gid_exp = g.req; end
          grant_seen++;
        end
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          chk("unexpected_word", {tx_last, tx_data}, 64'd0);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_data", 64'(tx_data), 64'(e.data));
          chk("tx_last", 64'(tx_last), 64'(e.last));
          if (tx_last) begin
            last_pending = 1'b1;
            $display("t=%0t link transaction end, last word %h", $time, tx_data);
          end
        end
      end
`ifdef SVCS_TRNX_TIMEOUT_EN
      if (err_timeout) to_seen++;
`else
      if (err_timeout) chk("err_timeout_tied", 64'(err_timeout), 64'd0);
`endif
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  task automatic set_hdr(input int r, input cs_hdr_t h);
    req_hdr[r*128 +: 128] = h;
  endtask

  task automatic push_word(input logic [31:0] d, input logic last);
    tx_exp_t e;
    e.data = d; e.last = last;
    exp_tx.push_back(e);
  endtask

  task automatic push_hdr(input cs_hdr_t h);
    push_word(h.trnx_type, 1'b0);
    push_word(h.trnx_id, 1'b0);
    push_word(h.data_type, 1'b0);
    push_word(h.n_payloads, h.n_payloads == 0);
  endtask

  task automatic push_pld(input int r, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      pq[r].push_back(base + 32'(i));
      push_word(base + 32'(i), i == n - 1);
    end
  endtask

  task automatic push_grant(input int r, input logic err);
    gnt_exp_t g;
    g.req = r; g.err = err;
    exp_grant.push_back(g);
  endtask

  task automatic wait_grant(input int target);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      if (grant_seen >= target) break;
    end
    chk("grant_wait", 64'(grant_seen >= target), 64'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #2;
      if (exp_tx.size() == 0 && exp_grant.size() == 0 && !busy) break;
    end
    chk("drain", 64'(exp_tx.size() + exp_grant.size()), 64'd0);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    cs_hdr_t h0, h1, h2, h3;
    int      g0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_tx_last", 64'(tx_last), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_pld_ready", 64'(pld_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_err", {err_len, err_timeout}, 64'd0);

    // Held requests from everyone, empty payloads: grants rotate 0,1,2,3,0
    for (int r = 0; r < N; r++) begin
      h0 = '{32'h4, 32'h40 + 32'(r), 32'h400 + 32'(r), 32'd0};
      set_hdr(r, h0);
    end
    for (int k = 0; k < 5; k++) begin
      h0 = '{32'h4, 32'h40 + 32'(k % 4), 32'h400 + 32'(k % 4), 32'd0};
      push_grant(k % 4, 1'b0);
      push_hdr(h0);
    end
    g0 = grant_seen;
    req_valid = 4'b1111;
    wait_grant(g0 + 5);
    req_valid = '0;
    wait_idle();

    // Single requester, three payloads at full rate
    h0 = '{32'h1, 32'h10, 32'h100, 32'd3};
    set_hdr(0, h0);
    push_grant(0, 1'b0);
    push_hdr(h0);
    push_pld(0, 32'hC0DE_0000, 3);
    g0 = grant_seen;
    req_valid = 4'b0001;
    wait_grant(g0 + 1);
    req_valid = '0;
    wait_idle();

    // Random link back-pressure through header and payload
    h1 = '{32'h2, 32'h21, 32'h201, 32'd5};
    set_hdr(1, h1);
    push_grant(1, 1'b0);
    push_hdr(h1);
    push_pld(1, 32'hB0B0_0000, 5);
    rand_mode = 1'b1;
    g0 = grant_seen;
    req_valid = 4'b0010;
    wait_grant(g0 + 1);
    req_valid = '0;
    wait_idle();
    rand_mode = 1'b0;
    wait_idle();

    // Oversize request from 2 is consumed silently; pointer moves on to 3, then 0
    h2 = '{32'h3, 32'h32, 32'h302, 32'd4097};
    h3 = '{32'h3, 32'h33, 32'h303, 32'd2};
    h0 = '{32'h3, 32'h30, 32'h300, 32'd0};
    set_hdr(2, h2); set_hdr(3, h3); set_hdr(0, h0);
    push_grant(2, 1'b1);
    push_grant(3, 1'b0);
    push_hdr(h3);
    push_pld(3, 32'h3333_0000, 2);
    push_grant(0, 1'b0);
    push_hdr(h0);
    g0 = grant_seen;
    req_valid = 4'b1101;
    wait_grant(g0 + 1);
    req_valid[2] = 1'b0;
    chk("no_tx_on_err", 64'(tx_valid), 64'd0);
    wait_grant(g0 + 2);
    req_valid[3] = 1'b0;
    wait_grant(g0 + 3);
    req_valid[0] = 1'b0;
    wait_idle();

    // Reset during the second payload of a ten-payload transaction
    h1 = '{32'h5, 32'h51, 32'h501, 32'd10};
    set_hdr(1, h1);
    push_grant(1, 1'b0);
    push_hdr(h1);
    for (int i = 0; i < 10; i++) pq[1].push_back(32'h5A5A_0000 + 32'(i));
    push_word(32'h5A5A_0000, 1'b0);
    g0 = grant_seen;
    req_valid = 4'b0010;
    wait_grant(g0 + 1);
    req_valid = '0;
    for (int k = 0; k < 200; k++) begin
      if (exp_tx.size() == 0) break;
      @(posedge clk); #2;
    end
    chk("pre_reset_words", 64'(exp_tx.size()), 64'd0);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_grant_id", 64'(grant_id), 64'd0);
    chk("mid_rst_pld_ready", 64'(pld_ready), 64'd0);
    // Pointer must be back at 0: requests from 0 and 2 go to 0 first
    h0 = '{32'h7, 32'h70, 32'h700, 32'd1};
    h2 = '{32'h7, 32'h72, 32'h702, 32'd0};
    set_hdr(0, h0); set_hdr(2, h2);
    push_grant(0, 1'b0);
    push_hdr(h0);
    push_pld(0, 32'h7000_0000, 1);
    push_grant(2, 1'b0);
    push_hdr(h2);
    g0 = grant_seen;
    req_valid = 4'b0101;
    wait_grant(g0 + 1);
    req_valid[0] = 1'b0;
    wait_grant(g0 + 2);
    req_valid[2] = 1'b0;
    wait_idle();

`ifdef SVCS_TRNX_TIMEOUT_EN
    // Payload source never asserts valid: abort word after eight stalled cycles
    h3 = '{32'h6, 32'h63, 32'h603, 32'd2};
    set_hdr(3, h3);
    push_grant(3, 1'b0);
    push_hdr(h3);
    push_word(32'hDEAD_DEAD, 1'b1);
    g0 = grant_seen;
    req_valid = 4'b1000;
    wait_grant(g0 + 1);
    req_valid = '0;
    wait_idle();
    chk("err_timeout_pulses", 64'(to_seen), 64'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
